// File: rtl/pipe_flow_ctrl_if.sv
// pipe_flow_ctrl_if: handshake bundle between the pipeline and its flow controller
//   master: pipeline side, drives hold/miss/load-use/redirect requests, receives stall/flush/redirect
//   slave : controller side
interface pipe_flow_ctrl_if #(
  parameter int STAGES = 5,
  parameter int NSRC   = 2,
  parameter int NRED   = 2,
  parameter int AW     = 32
);
  logic                hold_i;
  logic [NSRC-1:0]     src_req_i;
  logic [NSRC-1:0]     src_hit_i;
  logic [NSRC-1:0]     src_ready_i;
  logic                lu_i;
  logic [NRED-1:0]     redir_req_i;
  logic [NRED*AW-1:0]  redir_pc_i;
  logic [STAGES-1:0]   stall_o;
  logic [STAGES-2:0]   flush_o;
  logic                redir_valid_o;
  logic [AW-1:0]       redir_pc_o;
  logic [NSRC-1:0]     busy_o;
  modport master (
    output hold_i, src_req_i, src_hit_i, src_ready_i, lu_i, redir_req_i, redir_pc_i,
    input  stall_o, flush_o, redir_valid_o, redir_pc_o, busy_o
  );
  modport slave (
    input  hold_i, src_req_i, src_hit_i, src_ready_i, lu_i, redir_req_i, redir_pc_i,
    output stall_o, flush_o, redir_valid_o, redir_pc_o, busy_o
  );
endinterface

// File: rtl/pipe_flow_ctrl.sv
// pipe_flow_ctrl: merges miss/hold/load-use/redirect sources into per-stage stall and flush
//   clk, rst_n (async, active-low); bus (pipe_flow_ctrl_if.slave) carries all handshakes:
//   in : hold_i, src_req_i/src_hit_i/src_ready_i, lu_i, redir_req_i, redir_pc_i
//   out: stall_o, flush_o, redir_valid_o, redir_pc_o, busy_o
//   FC_PERF_EN adds perf_stall_cnt_o / perf_flush_cnt_o saturating counters
module pipe_flow_ctrl #(
  parameter int STAGES = 5,
  parameter int NSRC   = 2,
  parameter int NRED   = 2,
  parameter int AW     = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  pipe_flow_ctrl_if.slave bus
`ifdef FC_PERF_EN
  ,
  output logic [31:0] perf_stall_cnt_o,
  output logic [31:0] perf_flush_cnt_o
`endif
);
  localparam int IW = NRED > 1 ? $clog2(NRED) : 1;
  logic [NSRC-1:0]   busy_q, busy_d, new_miss, miss;
  logic [NRED-1:0]   taken_q, taken_d, elig;
  logic [IW-1:0]     sel;
  logic              any_elig, freeze, deliver, lu_apply;
  logic [STAGES-2:0] red_mask, lu_mask;
  assign new_miss = bus.src_req_i & ~bus.src_hit_i;
  // ready wins over a miss raised in the same cycle, so the ready cycle never stalls
  assign miss     = (busy_q | new_miss) & ~bus.src_ready_i;
  assign busy_d   = ~bus.src_ready_i & (busy_q | new_miss);
  assign freeze   = bus.hold_i | (|miss);
  // channel 0 sits in ID; a load-use bubble there holds it, so it must wait
  assign elig     = bus.redir_req_i & ~taken_q & ~{{(NRED-1){1'b0}}, bus.lu_i};
  always_comb begin
    any_elig = 1'b0;
    sel      = '0;
    for (int i = 0; i < NRED; i++)
      if (elig[i]) begin
        any_elig = 1'b1;
        sel      = IW'(i);
      end
  end
  assign deliver  = ~freeze & any_elig;
  assign lu_apply = ~freeze & ~deliver & bus.lu_i;
  always_comb begin
    red_mask = '0;
    for (int j = 0; j < STAGES - 1; j++) red_mask[j] = (j <= int'(sel));
  end
  assign lu_mask = (STAGES-1)'(2);
  // only the delivered channel is marked; dropped younger channels are flushed away
  always_comb begin
    taken_d = '0;
    for (int i = 0; i < NRED; i++)
      taken_d[i] = bus.redir_req_i[i] & (taken_q[i] | (deliver & (sel == IW'(i))));
  end
  assign bus.stall_o       = freeze ? '1 : lu_apply ? STAGES'(3) : '0;
  assign bus.flush_o       = deliver ? red_mask : lu_apply ? lu_mask : '0;
  assign bus.redir_valid_o = deliver;
  assign bus.redir_pc_o    = deliver ? bus.redir_pc_i[int'(sel)*AW +: AW] : '0;
  assign bus.busy_o        = busy_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      busy_q  <= '0;
      taken_q <= '0;
    end else begin
      busy_q  <= busy_d;
      taken_q <= taken_d;
    end
`ifdef FC_PERF_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_q + 32'((freeze | lu_apply) & ~&stall_cnt_q);
      flush_cnt_q <= flush_cnt_q + 32'(deliver & ~&flush_cnt_q);
    end
  assign perf_stall_cnt_o = stall_cnt_q;
  assign perf_flush_cnt_o = flush_cnt_q;
`endif
endmodule

// File: tb/tb_pipe_flow_ctrl.sv
// tb_pipe_flow_ctrl: directed vectors with a scoreboard queue checked by a separate monitor
module tb_pipe_flow_ctrl;
  localparam int STAGES = 5, NSRC = 2, NRED = 2, AW = 32;
  typedef struct {
    string       nm;
    logic [4:0]  st;
    logic [3:0]  fl;
    logic        v;
    logic [31:0] pc;
    logic [1:0]  bz;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t exp_q[$];
  pipe_flow_ctrl_if #(.STAGES(STAGES), .NSRC(NSRC), .NRED(NRED), .AW(AW)) bus ();
`ifdef FC_PERF_EN
  logic [31:0] perf_stall, perf_flush, s0, f0;
  pipe_flow_ctrl #(.STAGES(STAGES), .NSRC(NSRC), .NRED(NRED), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave),
    .perf_stall_cnt_o(perf_stall), .perf_flush_cnt_o(perf_flush));
`else
  pipe_flow_ctrl #(.STAGES(STAGES), .NSRC(NSRC), .NRED(NRED), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave));
`endif
  always #5 clk = ~clk;
  task automatic chk(input string nm, input string f, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s.%s: got %h expected %h", nm, f, act, req);
    end
  endtask
  initial forever begin
    @(negedge clk);
    while (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk(e.nm, "stall", 32'(bus.stall_o), 32'(e.st));
      chk(e.nm, "flush", 32'(bus.flush_o), 32'(e.fl));
      chk(e.nm, "valid", 32'(bus.redir_valid_o), 32'(e.v));
      chk(e.nm, "pc", bus.redir_pc_o, e.pc);
      chk(e.nm, "busy", 32'(bus.busy_o), 32'(e.bz));
    end
  end
  task automatic cyc(input string nm, input logic rn, input logic h, input logic [1:0] rq,
                     input logic [1:0] ht, input logic [1:0] rd, input logic l, input logic [1:0] rr,
                     input logic [31:0] p0, input logic [31:0] p1, input logic [4:0] es,
                     input logic [3:0] ef, input logic ev, input logic [31:0] ep, input logic [1:0] eb);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = rn;
    bus.hold_i = h;
    bus.src_req_i = rq;
    bus.src_hit_i = ht;
    bus.src_ready_i = rd;
    bus.lu_i = l;
    bus.redir_req_i = rr;
    bus.redir_pc_i = {p1, p0};
    e.nm = nm; e.st = es; e.fl = ef; e.v = ev; e.pc = ep; e.bz = eb;
    exp_q.push_back(e);
  endtask
  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
  initial begin
    bus.hold_i = 0; bus.src_req_i = 0; bus.src_hit_i = 0; bus.src_ready_i = 0;
    bus.lu_i = 0; bus.redir_req_i = 0; bus.redir_pc_i = '0;
    //   name       rn h  req   hit   rdy   lu rreq  pc0           pc1           stall     flush    v  pc            busy
    cyc("rst",      0, 0, 2'b00,2'b00,2'b00,0, 2'b00,32'h0,        32'h0,        5'b00000, 4'b0000, 0, 32'h0,        2'b00);
    cyc("idle",     1, 0, 2'b00,2'b00,2'b00,0, 2'b00,32'h0,        32'h0,        5'b00000, 4'b0000, 0, 32'h0,        2'b00);
    cyc("hit",      1, 0, 2'b01,2'b01,2'b00,0, 2'b00,32'h0,        32'h0,        5'b00000, 4'b0000, 0, 32'h0,        2'b00);
    cyc("miss3",    1, 0, 2'b01,2'b00,2'b00,0, 2'b00,32'h0,        32'h0,        5'b11111, 4'b0000, 0, 32'h0,        2'b00);
    cyc("miss4",    1, 0, 2'b00,2'b00,2'b00,0, 2'b00,32'h0,        32'h0,        5'b11111, 4'b0000, 0, 32'h0,        2'b01);
    cyc("miss5",    1, 0, 2'b00,2'b00,2'b00,0, 2'b00,32'h0,        32'h0,        5'b11111, 4'b0000, 0, 32'h0,        2'b01);
    cyc("miss6",    1, 0, 2'b00,2'b00,2'b00,0, 2'b00,32'h0,        32'h0,        5'b11111, 4'b0000, 0, 32'h0,        2'b01);
    cyc("ready7",   1, 0, 2'b00,2'b00,2'b01,0, 2'b00,32'h0,        32'h0,        5'b00000, 4'b0000, 0, 32'h0,        2'b01);
    cyc("after7",   1, 0, 2'b00,2'b00,2'b00,0, 2'b00,32'h0,        32'h0,        5'b00000, 4'b0000, 0, 32'h0,        2'b00);
    cyc("rdywin",   1, 0, 2'b01,2'b00,2'b01,0, 2'b00,32'h0,        32'h0,        5'b00000, 4'b0000, 0, 32'h0,        2'b00);
    cyc("rdywin2",  1, 0, 2'b00,2'b00,2'b00,0, 2'b00,32'h0,        32'h0,        5'b00000, 4'b0000, 0, 32'h0,        2'b00);
    cyc("ch1_a",    1, 0, 2'b00,2'b00,2'b00,0, 2'b10,32'h0,        32'h8000_0040,5'b00000, 4'b0011, 1, 32'h8000_0040,2'b00);
    cyc("ch1_b",    1, 0, 2'b00,2'b00,2'b00,0, 2'b10,32'h0,        32'h8000_0040,5'b00000, 4'b0000, 0, 32'h0,        2'b00);
    cyc("ch1_c",    1, 0, 2'b00,2'b00,2'b00,0, 2'b10,32'h0,        32'h8000_0040,5'b00000, 4'b0000, 0, 32'h0,        2'b00);
    cyc("ch1_d",    1, 0, 2'b00,2'b00,2'b00,0, 2'b10,32'h0,        32'h8000_0040,5'b00000, 4'b0000, 0, 32'h0,        2'b00);
    cyc("ch1_drop", 1, 0, 2'b00,2'b00,2'b00,0, 2'b00,32'h0,        32'h8000_0040,5'b00000, 4'b0000, 0, 32'h0,        2'b00);
    cyc("ch1_rearm",1, 0, 2'b00,2'b00,2'b00,0, 2'b10,32'h0,        32'h8000_0040,5'b00000, 4'b0011, 1, 32'h8000_0040,2'b00);
    cyc("ch1_end",  1, 0, 2'b00,2'b00,2'b00,0, 2'b00,32'h0,        32'h0,        5'b00000, 4'b0000, 0, 32'h0,        2'b00);
    cyc("both",     1, 0, 2'b00,2'b00,2'b00,0, 2'b11,32'h0000_1000,32'h0000_2000,5'b00000, 4'b0011, 1, 32'h0000_2000,2'b00);
    cyc("both_end", 1, 0, 2'b00,2'b00,2'b00,0, 2'b00,32'h0000_1000,32'h0000_2000,5'b00000, 4'b0000, 0, 32'h0,        2'b00);
    cyc("ch0",      1, 0, 2'b00,2'b00,2'b00,0, 2'b01,32'h0000_1000,32'h0,        5'b00000, 4'b0001, 1, 32'h0000_1000,2'b00);
    cyc("ch0_end",  1, 0, 2'b00,2'b00,2'b00,0, 2'b00,32'h0,        32'h0,        5'b00000, 4'b0000, 0, 32'h0,        2'b00);
    cyc("lu",       1, 0, 2'b00,2'b00,2'b00,1, 2'b00,32'h0,        32'h0,        5'b00011, 4'b0010, 0, 32'h0,        2'b00);
    cyc("lu_ch0",   1, 0, 2'b00,2'b00,2'b00,1, 2'b01,32'h0000_3000,32'h0,        5'b00011, 4'b0010, 0, 32'h0,        2'b00);
    cyc("ch0_late", 1, 0, 2'b00,2'b00,2'b00,0, 2'b01,32'h0000_3000,32'h0,        5'b00000, 4'b0001, 1, 32'h0000_3000,2'b00);
    cyc("lu_ch1",   1, 0, 2'b00,2'b00,2'b00,1, 2'b10,32'h0,        32'h0000_4000,5'b00000, 4'b0011, 1, 32'h0000_4000,2'b00);
    cyc("lu_end",   1, 0, 2'b00,2'b00,2'b00,0, 2'b00,32'h0,        32'h0,        5'b00000, 4'b0000, 0, 32'h0,        2'b00);
`ifdef FC_PERF_EN
    s0 = perf_stall;
    f0 = perf_flush;
`endif
    cyc("hold1",    1, 1, 2'b00,2'b00,2'b00,0, 2'b10,32'h0,        32'h8000_0060,5'b11111, 4'b0000, 0, 32'h0,        2'b00);
    cyc("hold2",    1, 1, 2'b00,2'b00,2'b00,1, 2'b10,32'h0,        32'h8000_0060,5'b11111, 4'b0000, 0, 32'h0,        2'b00);
    cyc("hold3",    1, 1, 2'b00,2'b00,2'b00,0, 2'b10,32'h0,        32'h8000_0060,5'b11111, 4'b0000, 0, 32'h0,        2'b00);
    cyc("hold_rel", 1, 0, 2'b00,2'b00,2'b00,0, 2'b10,32'h0,        32'h8000_0080,5'b00000, 4'b0011, 1, 32'h8000_0080,2'b00);
    cyc("hold_end", 1, 0, 2'b00,2'b00,2'b00,0, 2'b00,32'h0,        32'h0,        5'b00000, 4'b0000, 0, 32'h0,        2'b00);
`ifdef FC_PERF_EN
    chk("perf", "stall_delta", perf_stall - s0, 32'd3);
    chk("perf", "flush_delta", perf_flush - f0, 32'd1);
`endif
    cyc("miss1",    1, 0, 2'b10,2'b00,2'b00,0, 2'b00,32'h0,        32'h0,        5'b11111, 4'b0000, 0, 32'h0,        2'b00);
    cyc("miss1_b",  1, 0, 2'b00,2'b00,2'b00,0, 2'b00,32'h0,        32'h0,        5'b11111, 4'b0000, 0, 32'h0,        2'b10);
    cyc("arst",     0, 0, 2'b00,2'b00,2'b00,0, 2'b00,32'h0,        32'h0,        5'b00000, 4'b0000, 0, 32'h0,        2'b00);
    cyc("arst_rel", 1, 0, 2'b00,2'b00,2'b00,0, 2'b00,32'h0,        32'h0,        5'b00000, 4'b0000, 0, 32'h0,        2'b00);
    @(posedge clk);
    #1;
    chk("drain", "queue", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/pipe_flow_ctrl.md
# pipe_flow_ctrl

Parametrised pipeline flow controller for the core: merges N stall sources with cache-style req/hit/ready handshakes, a global hold, a load-use hazard and R prioritised redirect (jump/branch) channels. It drives per-stage stall and per-pipeline-register flush vectors, plus a single redirect PC to the fetch stage. Each redirect request fires exactly once per assertion and is deferred, not lost, while the pipeline is frozen. It sits beside the pipeline, replacing hand-wired per-stage stall/flush logic.

## Interface
- STAGES, 5, pipeline stages; stage 0 = IF. Range 3..8.
- NSRC, 2, miss-capable stall sources, e.g. Icache and Dcache/bus.
- NRED, 2, redirect channels; channel i originates in stage i+1. Range 1..STAGES-2.
- AW, 32, PC width.
- clk  in  1  core clock.
- rst_n  in  1  reset; asynchronous, active-low.
- hold_i  in  1  global wait; freezes everything.
- src_req_i  in  NSRC  source k issued a request this cycle.
- src_hit_i  in  NSRC  request of source k hit in the same cycle.
- src_ready_i  in  NSRC  refill/bus response of source k done.
- lu_i  in  1  load-use hazard detected in ID.
- redir_req_i  in  NRED  redirect request per channel; level, held while its stage holds the instruction.
- redir_pc_i  in  NRED*AW  target PC; channel i occupies bits [i*AW +: AW].
- stall_o  out  STAGES  bit s holds stage s.
- flush_o  out  STAGES-1  bit j loads a bubble into the register after stage j.
- redir_valid_o  out  1  redirect delivered this cycle.
- redir_pc_o  out  AW  selected target; 0 when redir_valid_o=0.
- busy_o  out  NSRC  source k outstanding miss (busy_q).

## Operation
- Miss tracking, per source k: busy_q[k] next = src_ready_i ? 0 : (src_req_i & ~src_hit_i) ? 1 : busy_q. miss[k] = (busy_q[k] | (src_req_i & ~src_hit_i)) & ~src_ready_i. Ready wins over a simultaneous new miss.
- freeze = hold_i | OR(miss). When freeze=1: stall_o all ones, flush_o 0, redir_valid_o 0, lu ignored.
- Redirect eligibility: elig[i] = redir_req_i[i] & ~taken_q[i]. Channel 0 is also ineligible while lu_i=1.
- taken_q[i] is set when channel i is delivered. It clears when redir_req_i[i]=0, giving one firing per request assertion.
- Selection when not frozen: the highest eligible index wins (oldest instruction).
  - redir_valid_o=1; redir_pc_o = that channel's PC.
  - flush_o[0..i]=1; stall_o 0.
  - Younger eligible channels are dropped, and their taken_q is not set. Their stages are flushed, so their requests vanish.
- Load-use, not frozen, no redirect delivered: stall_o[0]=stall_o[1]=1 and flush_o[1]=1, inserting a bubble into ID/EX.
- Otherwise all outputs 0.

## Timing
- All outputs are combinational from inputs and state within the same cycle. There are no registered outputs.
- State is busy_q, taken_q, and optionally the perf counters. All are reset to 0 asynchronously.
- During reset and with idle inputs: stall_o=0, flush_o=0, redir_valid_o=0, redir_pc_o=0, busy_o=0.
- A miss stalls in the cycle of the missing request and stays stalled until and including the cycle before src_ready_i. The ready cycle itself is unstalled.
- A redirect raised while frozen is delivered in the first unfrozen cycle, using the PC presented in that cycle.
- A request held high for N cycles produces one delivery. Deasserting for at least 1 cycle re-arms it.
- Reset asserted mid-miss clears busy_q immediately, so stall drops asynchronously.

## Configuration
- FC_PERF_EN defined: adds ports perf_stall_cnt_o (out, 32) and perf_flush_cnt_o (out, 32).
  - perf_stall_cnt_o counts cycles with freeze or an applied load-use bubble.
  - perf_flush_cnt_o counts delivered redirects.
  - Both saturate at 32'hFFFF_FFFF and reset to 0.
- FC_PERF_EN undefined: these ports and counters do not exist; all other behaviour is identical.

## Test plan
- Source 0 req/miss at cycle 3, ready at cycle 7 -> stall_o=5'b11111 in cycles 3–6; busy_o[0]=1 in cycles 4–6; stall_o=0 in cycle 7.
- Channel 1 held high 4 cycles, PC 0x8000_0040 -> exactly one cycle with redir_valid_o=1, redir_pc_o=0x8000_0040, flush_o=4'b0011. Drop for 1 cycle and re-raise -> fires again.
- Channels 0 and 1 raised in the same cycle -> channel 1 PC delivered, flush_o=4'b0011; channel 0 does not fire in the next cycle once its request drops.
- lu_i=1 alone -> stall_o=5'b00011, flush_o=4'b0010. lu_i together with channel 0 -> load-use applied, no redirect. lu_i together with channel 1 -> redirect only.
- hold_i high 3 cycles while channel 1 is requested -> no delivery during hold; delivery in the first cycle after hold drops. With FC_PERF_EN: stall count +3, flush count +1.
- rst_n pulsed low while busy_q[1]=1 -> busy_o and stall_o go to 0 immediately, without waiting for a clock edge.
